flash_word_reader: RTL
======================

Name: flash_word_reader

Overview:
- Read sequencer directly upstream/downstream of the SPI flash master.
- Given a start byte address and a word count, it issues one address per 32-bit word to the master and collects each returned word.
- Buffers the words in a small FIFO and presents them as a valid/ready stream with a last flag.
- Used by boot/asset loaders that copy flash contents into BRAM or feed a display/audio path.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words buffered (power of two, >=2).
- COUNT_W, 16, width of the word_count input.
- SWAP_BYTES, 0, 0: first flash byte lands in out_data[31:24]; 1: first flash byte lands in out_data[7:0].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a burst; ignored while busy=1
- start_addr  in  24  byte address of first word
- word_count  in  COUNT_W  number of 32-bit words to read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when burst is complete and the FIFO is drained
- fl_addr_en  out  1  one-cycle address strobe to the flash master
- fl_addr_data  out  24  address presented with fl_addr_en
- fl_rd_data_available  in  1  master holds a word; stays high until acked
- fl_rd_ack  out  1  one-cycle acknowledge to the flash master
- fl_rd_data  in  32  word from master, first serial byte in [31:24]
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer ready
- out_data  out  32  stream word
- out_last  out  1  high with the final word of a burst

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is synchronous and active-high on reset.
  - Reset values: busy=0, done=0, fl_addr_en=0, fl_addr_data=0, fl_rd_ack=0, out_valid=0, out_last=0, out_data=0, FIFO empty, state IDLE.
- State machine: IDLE, ISSUE, WAIT_DATA, ACK_GAP, DRAIN.
- IDLE:
  - On start=1: latch addr=start_addr and remaining=word_count; busy<=1.
  - If word_count!=0, go to ISSUE.
  - If word_count==0, go to DRAIN, which pulses done the next cycle with no flash traffic.
  - If fl_rd_data_available=1 while in IDLE (a stale word left from a transfer aborted by reset), pulse fl_rd_ack for one cycle and discard the word. start is deferred until this completes.
- ISSUE:
  - Proceed only if FIFO occupancy < FIFO_DEPTH.
  - Then drive fl_addr_en=1 with fl_addr_data=addr for exactly one cycle and go to WAIT_DATA.
  - fl_addr_en is never held for two consecutive cycles.
- WAIT_DATA:
  - When fl_rd_data_available=1: push fl_rd_data (byte-swapped if SWAP_BYTES=1) into the FIFO, tagged last=(remaining==1).
  - In the same cycle: fl_rd_ack<=1 for one cycle, addr<=addr+4 (mod 2^24, so 0xFFFFFC wraps to 0x000000), remaining<=remaining-1.
  - Go to ACK_GAP.
  - No timeout; the block waits indefinitely.
- ACK_GAP:
  - One cycle so the master can drop fl_rd_data_available.
  - fl_rd_data_available is not sampled in this state.
  - Then go to ISSUE if remaining!=0, else DRAIN.
- DRAIN:
  - Wait for the FIFO to empty.
  - Then pulse done for one cycle, busy<=0, and go to IDLE.
  - A start in the same cycle as done is ignored.
- Flow control: at most one word is in flight. Because ISSUE checks occupancy before issuing, the push in WAIT_DATA always has room and no overflow is possible.
- Stream output:
  - out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop keeps occupancy unchanged; push into an empty FIFO shows out_valid the next cycle.
  - out_data is stable while out_valid && !out_ready.
- Reset mid-burst:
  - All state and the FIFO are cleared.
  - The master does not reset, so a pending word is drained by the IDLE stale-word rule.
- Throughput bound: one word per (flash transaction + 3) cycles.

Decomposition:
- Package flash_reader_pkg:
  - State encoding constants for the five states.
  - FLASH_ADDR_W=24 and FLASH_WORD_W=32.
  - WORD_BYTES=4, the address increment.
- Sub-module sync_fifo:
  - Parameters: width 33 (data + last) and FIFO_DEPTH.
  - Ports: push, pop, full, empty, count.
  - Synchronous reset, registered read output of the head.

Test Plan:
- Basic burst: start_addr=0x000100, word_count=3, flash model returns 0x11223344/0x55667788/0x99AABBCC, out_ready=1 → fl_addr_data sequence 0x000100, 0x000104, 0x000108. Stream carries the 3 words in order with out_last only on the 3rd. done pulses once, then busy=0.
- Back-pressure: word_count=8, FIFO_DEPTH=4, out_ready=0 → exactly 4 fl_addr_en pulses, then none. Raising out_ready yields all 8 words in order, with no loss or duplication.
- Zero count: start with word_count=0 → no fl_addr_en. done pulses 2 cycles after start; busy is high for exactly those cycles.
- Address wrap: start_addr=0xFFFFF8, word_count=3 → addresses 0xFFFFF8, 0xFFFFFC, 0x000000.
- Reset mid-operation: assert reset while in WAIT_DATA, with the model raising fl_rd_data_available 5 cycles after reset. Block pulses fl_rd_ack once, emits no stream word, and a following start(addr 0x000040, count 1) completes normally.
- SWAP_BYTES=1: flash word 0xDEADBEEF → out_data=0xEFBEADDE. A start pulse while busy=1 is ignored, and the address sequence is unchanged.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// Shared definitions for the flash word reader: FSM encoding, bus widths
// and the byte-lane swap helper.
package flash_reader_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_WORD_W = 32;
    localparam int WORD_BYTES   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_ACK_GAP   = 3'd3,
        ST_DRAIN     = 3'd4
    } reader_state_e;

    // Reverse the byte lanes so the first serial flash byte lands in [7:0].
    function automatic logic [FLASH_WORD_W-1:0] swap_bytes32(input logic [FLASH_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output. The head
// register is reloaded every cycle with whatever entry will be at the front
// after this cycle's push/pop, so the consumer never sees a read latency.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] head_q;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [WIDTH-1:0] head_d;
    logic             full_s;
    logic             empty_s;

    // Qualify push/pop and work out which entry is the head next cycle.
    always_comb begin
        full_s    = (count_q == CNT_W'(DEPTH));
        empty_s   = (count_q == '0);
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = head_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;

endmodule

// File: rtl/flash_word_reader.sv
// Burst read sequencer in front of the SPI flash master: issues one address
// per 32-bit word, collects each returned word into a small FIFO and streams
// the words out with a last flag. At most one word is in flight, and a word
// is only requested when the FIFO has room for it.
module flash_word_reader
    import flash_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16,
    parameter int SWAP_BYTES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [FLASH_ADDR_W-1:0] start_addr,
    input  logic [COUNT_W-1:0]      word_count,
    output logic                    busy,
    output logic                    done,
    output logic                    fl_addr_en,
    output logic [FLASH_ADDR_W-1:0] fl_addr_data,
    input  logic                    fl_rd_data_available,
    output logic                    fl_rd_ack,
    input  logic [FLASH_WORD_W-1:0] fl_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FLASH_WORD_W-1:0] out_data,
    output logic                    out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    reader_state_e             state_q;
    logic [FLASH_ADDR_W-1:0]   addr_q;
    logic [COUNT_W-1:0]        remaining_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      addr_en_q;
    logic [FLASH_ADDR_W-1:0]   addr_data_q;
    logic                      ack_q;
    logic                      pend_q;
    logic [FLASH_ADDR_W-1:0]   pend_addr_q;
    logic [COUNT_W-1:0]        pend_count_q;

    logic [FLASH_WORD_W-1:0]   word_s;
    logic                      last_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      start_ok_s;
    logic [FLASH_ADDR_W-1:0]   launch_addr_s;
    logic [COUNT_W-1:0]        launch_count_s;
    logic [FLASH_WORD_W:0]     head_s;
    logic                      full_s;
    logic                      empty_s;
    logic [CNT_W-1:0]          count_s;

    // Byte ordering, push qualification and launch source selection.
    always_comb begin
        if (SWAP_BYTES != 0) begin
            word_s = swap_bytes32(fl_rd_data);
        end else begin
            word_s = fl_rd_data;
        end
        last_s     = (remaining_q == COUNT_W'(1));
        push_s     = (state_q == ST_WAIT_DATA) && fl_rd_data_available;
        pop_s      = !empty_s && out_ready;
        // A start coinciding with done belongs to the finished burst; drop it.
        start_ok_s = start && !done_q;
        if (start_ok_s) begin
            launch_addr_s  = start_addr;
            launch_count_s = word_count;
        end else begin
            launch_addr_s  = pend_addr_q;
            launch_count_s = pend_count_q;
        end
    end

    sync_fifo #(
        .WIDTH (FLASH_WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({last_s, word_s}),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_en_q    <= 1'b0;
            addr_data_q  <= '0;
            ack_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_count_q <= '0;
        end else begin
            done_q    <= 1'b0;
            addr_en_q <= 1'b0;
            ack_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fl_rd_data_available && !ack_q) begin
                        // Word left over from a burst cut short by reset.
                        ack_q <= 1'b1;
                        if (start_ok_s) begin
                            pend_q       <= 1'b1;
                            pend_addr_q  <= start_addr;
                            pend_count_q <= word_count;
                        end
                    end else if (ack_q) begin
                        // Master is still dropping the stale word this cycle.
                        if (start_ok_s) begin
                            pend_q       <= 1'b1;
                            pend_addr_q  <= start_addr;
                            pend_count_q <= word_count;
                        end
                    end else if (start_ok_s || pend_q) begin
                        pend_q      <= 1'b0;
                        addr_q      <= launch_addr_s;
                        remaining_q <= launch_count_s;
                        busy_q      <= 1'b1;
                        if (launch_count_s != '0) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!full_s) begin
                        addr_en_q   <= 1'b1;
                        addr_data_q <= addr_q;
                        state_q     <= ST_WAIT_DATA;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_WAIT_DATA: begin
                    if (fl_rd_data_available) begin
                        ack_q       <= 1'b1;
                        addr_q      <= addr_q + FLASH_ADDR_W'(WORD_BYTES);
                        remaining_q <= remaining_q - COUNT_W'(1);
                        state_q     <= ST_ACK_GAP;
                    end else begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_ACK_GAP: begin
                    if (remaining_q != '0) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_s == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign fl_addr_en   = addr_en_q;
    assign fl_addr_data = addr_data_q;
    assign fl_rd_ack    = ack_q;
    assign out_valid    = !empty_s;
    assign out_data     = head_s[FLASH_WORD_W-1:0];
    assign out_last     = head_s[FLASH_WORD_W];

endmodule
